ps2_mouse_rx: RTL and testbench

Receives the raw PS/2 mouse clock/data lines, deserializes 11-bit device-to-host frames, assembles 3-byte stream-mode packets, and presents per-packet X/Y displacement and button state. It sits directly upstream of the cursor-position block. That block consumes `x_displacement` and `y_displacement` as 8-bit two's-complement values in bits [7:0], with 0..127 positive, 128..255 negative, and Y positive downward.

---
 rtl/ps2_mouse_rx_if.sv | 31 +++
 rtl/ps2_mouse_rx.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_mouse_rx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_rx_if.sv
// Bundles the PS/2 line inputs and the decoded packet outputs of ps2_mouse_rx.
// slave = receiver side, master = the environment driving the lines and reading packets.
interface ps2_mouse_rx_if;
  logic        PS2_CLK;
  logic        PS2_DAT;
  logic [31:0] x_displacement;
  logic [31:0] y_displacement;
  logic [2:0]  buttons;
  logic        packet_valid;
  logic        frame_err;

  modport master (
    output PS2_CLK,
    output PS2_DAT,
    input  x_displacement,
    input  y_displacement,
    input  buttons,
    input  packet_valid,
    input  frame_err
  );

  modport slave (
    input  PS2_CLK,
    input  PS2_DAT,
    output x_displacement,
    output y_displacement,
    output buttons,
    output packet_valid,
    output frame_err
  );
endinterface

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse stream-mode receiver: line conditioning, 11-bit frame FSM, 3-byte packet decode.
// Optional odd-parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
//
// state    | meaning
// ---------+------------------------------------------------------
// S_IDLE   | waiting for a start bit (sampled 0)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the parity bit
// S_STOP   | checking the stop bit, accepting or rejecting the byte
module ps2_mouse_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic           Clk,
  input  logic           Reset,
  ps2_mouse_rx_if.slave  bus
);

  localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FLT_W-1:0] FLT_LOAD = FLT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic [1:0]       clk_sync;
  logic [1:0]       dat_sync;
  logic             ps2_clk_s;
  logic             ps2_dat_s;
  logic             clk_flt;
  logic [FLT_W-1:0] flt_cnt;
  logic             flt_accept;
  logic             fall_edge;

  state_t           state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             par_bit;
  logic [1:0]       byte_idx;
  logic [2:0]       btn_hdr;
  logic             x_sgn;
  logic             y_sgn;
  logic             x_ovf;
  logic             y_ovf;
  logic [7:0]       x_mag;
  logic [TO_W-1:0]  to_cnt;
  logic             timer_active;
  logic             parity_ok;

  logic signed [9:0] x_val;
  logic signed [9:0] y_raw;
  logic signed [9:0] y_val;
  logic [7:0]        x_res;
  logic [7:0]        y_res;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], bus.PS2_CLK};
      dat_sync <= {dat_sync[0], bus.PS2_DAT};
    end
  end

  assign ps2_clk_s = clk_sync[1];
  assign ps2_dat_s = dat_sync[1];

  // A new clock level is accepted on the FILTER_LEN-th consecutive differing sample.
  assign flt_accept = (ps2_clk_s != clk_flt) && (flt_cnt == '0);
  assign fall_edge  = flt_accept && !ps2_clk_s;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clk_flt <= 1'b1;
      flt_cnt <= FLT_LOAD;
    end else if (ps2_clk_s == clk_flt) begin
      flt_cnt <= FLT_LOAD;
    end else if (flt_cnt == '0) begin
      clk_flt <= ps2_clk_s;
      flt_cnt <= FLT_LOAD;
    end else begin
      flt_cnt <= flt_cnt - 1'b1;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shift_reg, par_bit};
`else
  logic par_unused;
  assign par_unused = par_bit;
  assign parity_ok  = 1'b1;
`endif

  function automatic logic [7:0] clamp_s8(input logic signed [9:0] v,
                                          input logic ovf,
                                          input logic neg);
    logic [7:0] r;
    if (ovf)
      r = neg ? 8'h81 : 8'h7F;
    else if (v > 10'sd127)
      r = 8'h7F;
    else if (v < -10'sd127)
      r = 8'h81;
    else
      r = v[7:0];
    return r;
  endfunction

  // PS/2 reports Y up-positive; the cursor block wants screen-down positive.
  always_comb begin
    x_val = {x_sgn, x_sgn, x_mag};
    y_raw = {y_sgn, y_sgn, shift_reg};
    y_val = 10'sd0 - y_raw;
    x_res = clamp_s8(x_val, x_ovf, x_sgn);
    y_res = clamp_s8(y_val, y_ovf, ~y_sgn);
  end

  assign timer_active = (state != S_IDLE) || (byte_idx != 2'd0);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state              <= S_IDLE;
      bit_cnt            <= 3'd0;
      shift_reg          <= 8'd0;
      par_bit            <= 1'b0;
      byte_idx           <= 2'd0;
      btn_hdr            <= 3'd0;
      x_sgn              <= 1'b0;
      y_sgn              <= 1'b0;
      x_ovf              <= 1'b0;
      y_ovf              <= 1'b0;
      x_mag              <= 8'd0;
      to_cnt             <= TO_LOAD;
      bus.x_displacement <= 32'd0;
      bus.y_displacement <= 32'd0;
      bus.buttons        <= 3'd0;
      bus.packet_valid   <= 1'b0;
      bus.frame_err      <= 1'b0;
    end else begin
      bus.packet_valid <= 1'b0;
      bus.frame_err    <= 1'b0;
      if (fall_edge) begin
        to_cnt <= TO_LOAD;
        case (state)
          S_IDLE: begin
            if (!ps2_dat_s) begin
              state   <= S_DATA;
              bit_cnt <= 3'd0;
            end
          end
          S_DATA: begin
            shift_reg <= {ps2_dat_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= ps2_dat_s;
            state   <= S_STOP;
          end
          S_STOP: begin
            state <= S_IDLE;
            if (ps2_dat_s && parity_ok) begin
              case (byte_idx)
                2'd0: begin
                  // Bit 3 is always set in a header; anything else is dropped to resync.
                  if (shift_reg[3]) begin
                    btn_hdr  <= shift_reg[2:0];
                    x_sgn    <= shift_reg[4];
                    y_sgn    <= shift_reg[5];
                    x_ovf    <= shift_reg[6];
                    y_ovf    <= shift_reg[7];
                    byte_idx <= 2'd1;
                  end
                end
                2'd1: begin
                  x_mag    <= shift_reg;
                  byte_idx <= 2'd2;
                end
                default: begin
                  bus.x_displacement <= {24'd0, x_res};
                  bus.y_displacement <= {24'd0, y_res};
                  bus.buttons        <= btn_hdr;
                  bus.packet_valid   <= 1'b1;
                  byte_idx           <= 2'd0;
                end
              endcase
            end else begin
              bus.frame_err <= 1'b1;
              byte_idx      <= 2'd0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (timer_active) begin
        if (to_cnt == '0) begin
          state         <= S_IDLE;
          byte_idx      <= 2'd0;
          bus.frame_err <= 1'b1;
          to_cnt        <= TO_LOAD;
        end else begin
          to_cnt <= to_cnt - 1'b1;
        end
      end else begin
        to_cnt <= TO_LOAD;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed self-checking bench for ps2_mouse_rx: bit-bangs PS/2 frames and checks decoded packets.
module tb_ps2_mouse_rx;
  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int HALF           = 20;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;

  ps2_mouse_rx_if bus();

  ps2_mouse_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  int tests    = 0;
  int fails    = 0;
  int pv_cnt   = 0;
  int fe_cnt   = 0;
  int both_cnt = 0;
  int pv0;
  int fe0;

  always @(negedge Clk) begin
    if (bus.packet_valid) pv_cnt <= pv_cnt + 1;
    if (bus.frame_err) fe_cnt <= fe_cnt + 1;
    if (bus.packet_valid && bus.frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^data) ^ bad_par, data, 1'b0};
    for (int i = 0; i < 11; i++) begin
      bus.PS2_DAT = f[i];
      wait_clk(HALF);
      bus.PS2_CLK = 1'b0;
      wait_clk(HALF);
      bus.PS2_CLK = 1'b1;
    end
    bus.PS2_DAT = 1'b1;
    wait_clk(3 * HALF);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_frame(b0, 1'b0, 1'b0);
    send_frame(b1, 1'b0, 1'b0);
    send_frame(b2, 1'b0, 1'b0);
  endtask

  task automatic packet_case(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] ex, input logic [7:0] ey,
                             input logic [2:0] eb);
    pv0 = pv_cnt;
    fe0 = fe_cnt;
    send_packet(b0, b1, b2);
    check({tag, "_pv"},  pv_cnt - pv0, 1);
    check({tag, "_fe"},  fe_cnt - fe0, 0);
    check({tag, "_x"},   bus.x_displacement, {24'd0, ex});
    check({tag, "_y"},   bus.y_displacement, {24'd0, ey});
    check({tag, "_btn"}, bus.buttons, eb);
  endtask

  initial begin
    logic [10:0] part;
    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    Reset = 1'b0;
    wait_clk(5);
    @(negedge Clk);
    check("rst_x",   bus.x_displacement, 0);
    check("rst_y",   bus.y_displacement, 0);
    check("rst_btn", bus.buttons, 0);
    check("rst_pv",  bus.packet_valid, 0);
    check("rst_fe",  bus.frame_err, 0);
    Reset = 1'b1;
    wait_clk(10);

    packet_case("p1",   8'h08, 8'h05, 8'h03, 8'h05, 8'hFD, 3'b000);
    packet_case("p2",   8'h39, 8'hF6, 8'hFE, 8'hF6, 8'h02, 3'b001);
    packet_case("xovf", 8'h48, 8'h10, 8'h00, 8'h7F, 8'h00, 3'b000);
    packet_case("clmp", 8'h38, 8'h00, 8'h00, 8'h81, 8'h7F, 3'b000);
    packet_case("yovf", 8'h88, 8'h00, 8'h10, 8'h00, 8'h81, 3'b000);

    // Stray byte without bit 3 must be dropped silently before a real header.
    fe0 = fe_cnt;
    send_frame(8'h00, 1'b0, 1'b0);
    check("resync_fe", fe_cnt - fe0, 0);
    packet_case("resync", 8'h0A, 8'h01, 8'h01, 8'h01, 8'hFF, 3'b010);

    pv0 = pv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h08, 1'b0, 1'b1);
    check("stop_fe", fe_cnt - fe0, 1);
    check("stop_pv", pv_cnt - pv0, 0);
    check("stop_x",  bus.x_displacement, 32'h01);

    pv0 = pv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h08, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("par_fe", fe_cnt - fe0, 1);
    check("par_pv", pv_cnt - pv0, 0);
    check("par_x",  bus.x_displacement, 32'h01);
    check("par_y",  bus.y_displacement, 32'hFF);
`else
    check("par_fe", fe_cnt - fe0, 0);
    check("par_pv", pv_cnt - pv0, 1);
    check("par_x",  bus.x_displacement, 32'h07);
    check("par_y",  bus.y_displacement, 32'h00);
`endif
    packet_case("after_par", 8'h09, 8'h02, 8'h04, 8'h02, 8'hFC, 3'b001);

    pv0 = pv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h08, 1'b0, 1'b0);
    send_frame(8'h05, 1'b0, 1'b0);
    wait_clk(TIMEOUT_CYCLES + 1 + 20);
    check("to_fe", fe_cnt - fe0, 1);
    check("to_pv", pv_cnt - pv0, 0);
    check("to_x",  bus.x_displacement, 32'h02);
    packet_case("after_to", 8'h08, 8'h05, 8'h03, 8'h05, 8'hFD, 3'b000);

    // Start a header byte, then pulse reset after a few data bits.
    part = {1'b1, 1'b0, 8'h08, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bus.PS2_DAT = part[i];
      wait_clk(HALF);
      bus.PS2_CLK = 1'b0;
      wait_clk(HALF);
      bus.PS2_CLK = 1'b1;
    end
    Reset = 1'b0;
    wait_clk(3);
    @(negedge Clk);
    check("mrst_x",   bus.x_displacement, 0);
    check("mrst_y",   bus.y_displacement, 0);
    check("mrst_btn", bus.buttons, 0);
    check("mrst_pv",  bus.packet_valid, 0);
    check("mrst_fe",  bus.frame_err, 0);
    bus.PS2_DAT = 1'b1;
    Reset = 1'b1;
    wait_clk(10);
    packet_case("after_rst", 8'h0A, 8'h01, 8'h01, 8'h01, 8'hFF, 3'b010);

    check("pv_fe_excl", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
